// File: rtl/seq_hit_monitor.sv
// seq_hit_monitor
//
// Consumes the one-bit detect output of an overlapping "1010" detector, counts
// detections over fixed windows of WIN_LEN cycles and reports each window's
// count. A sticky alarm is raised whenever a completed window reaches THRESH,
// and a saturating lifetime total of counted hits is kept. All outputs are
// registered.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset, overrides everything
//   en           monitor enable (level); dropping it aborts the current window
//   clr          one-cycle pulse, clears alarm and total_count
//   hit_in       detector output, one hit per high cycle
//   win_count    count of the last completed window (saturated)
//   win_done     one-cycle pulse, win_count was just updated
//   alarm        sticky, set when a completed window count >= THRESH
//   total_count  saturating count of all hits seen while counting
//   busy         high while a window is being counted

module seq_hit_monitor #(
    parameter int CNT_W   = 8,
    parameter int WIN_LEN = 16,
    parameter int THRESH  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             hit_in,
    output logic [CNT_W-1:0] win_count,
    output logic             win_done,
    output logic             alarm,
    output logic [CNT_W-1:0] total_count,
    output logic             busy
);

    localparam int               CYC_W    = $clog2(WIN_LEN);
    localparam logic [CYC_W-1:0] LAST_CYC = CYC_W'(WIN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] THRESH_V = CNT_W'(THRESH);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [CYC_W-1:0] cyc, cyc_nxt;
    logic [CNT_W-1:0] acc, acc_nxt;
    logic [CNT_W-1:0] win_count_nxt;
    logic [CNT_W-1:0] total_nxt;
    logic             win_done_nxt;
    logic             alarm_nxt;

    // Accumulator plus this cycle's hit, clamped so it never wraps.
    logic [CNT_W-1:0] acc_sum;
    // A hit only counts when the window is live and not being aborted.
    logic             counted;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        counted       = (state == COUNT) && en;
        acc_sum       = (hit_in && (acc != CNT_MAX)) ? acc + CNT_W'(1) : acc;
        state_nxt     = state;
        cyc_nxt       = cyc;
        acc_nxt       = acc;
        win_count_nxt = win_count;
        win_done_nxt  = 1'b0;
        // clr clears first; a window end or counted hit below may override.
        alarm_nxt     = alarm & ~clr;
        total_nxt     = clr ? '0 : total_count;

        case (state)
            IDLE: begin
                if (en) begin
                    state_nxt = COUNT;
                    cyc_nxt   = '0;
                    acc_nxt   = '0;
                end
            end
            COUNT: begin
                if (!en) begin
                    // Abort: partial window is dropped, reports untouched.
                    state_nxt = IDLE;
                end else if (cyc == LAST_CYC) begin
                    // Window end: report and restart with no gap cycle.
                    win_count_nxt = acc_sum;
                    win_done_nxt  = 1'b1;
                    if (acc_sum >= THRESH_V) begin
                        alarm_nxt = 1'b1;
                    end
                    cyc_nxt = '0;
                    acc_nxt = '0;
                end else begin
                    acc_nxt = acc_sum;
                    cyc_nxt = cyc + CYC_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // After clr, so a coinciding counted hit lands on a cleared total.
        if (counted && hit_in && (total_nxt != CNT_MAX)) begin
            total_nxt = total_nxt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            state       <= IDLE;
            cyc         <= '0;
            acc         <= '0;
            win_count   <= '0;
            win_done    <= 1'b0;
            alarm       <= 1'b0;
            total_count <= '0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            cyc         <= cyc_nxt;
            acc         <= acc_nxt;
            win_count   <= win_count_nxt;
            win_done    <= win_done_nxt;
            alarm       <= alarm_nxt;
            total_count <= total_nxt;
            busy        <= (state_nxt == COUNT);
        end
    end

endmodule

// File: tb/tb_seq_hit_monitor.sv
// Self-checking bench for seq_hit_monitor.
// Main instance (CNT_W=8, WIN_LEN=16, THRESH=3) is driven by directed and
// random stimulus; a reference model built from window-level rules (a queue
// of the current window's hits, summed when it fills) predicts every output.
// Window reports are pushed to a scoreboard queue and popped by a monitor
// on the falling edge whenever win_done is seen. A second instance
// (CNT_W=4, WIN_LEN=32) covers count saturation.

module tb_seq_hit_monitor;

    localparam int CNT_W    = 8;
    localparam int WIN_LEN  = 16;
    localparam int THRESH   = 3;
    localparam int MAX      = (1 << CNT_W) - 1;
    localparam int CNT_W2   = 4;
    localparam int WIN_LEN2 = 32;
    localparam int MAX2     = (1 << CNT_W2) - 1;

    logic              clk = 1'b0;
    logic              rst, en, clr, hit_in;
    logic [CNT_W-1:0]  win_count, total_count;
    logic              win_done, alarm, busy;

    logic              en2, hit2;
    logic [CNT_W2-1:0] win_count2, total_count2;
    logic              win_done2, alarm2, busy2;

    always #5 clk = ~clk;

    seq_hit_monitor #(.CNT_W(CNT_W), .WIN_LEN(WIN_LEN), .THRESH(THRESH)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .hit_in(hit_in),
        .win_count(win_count), .win_done(win_done), .alarm(alarm),
        .total_count(total_count), .busy(busy)
    );

    seq_hit_monitor #(.CNT_W(CNT_W2), .WIN_LEN(WIN_LEN2), .THRESH(3)) dut_sat (
        .clk(clk), .rst(rst), .en(en2), .clr(1'b0), .hit_in(hit2),
        .win_count(win_count2), .win_done(win_done2), .alarm(alarm2),
        .total_count(total_count2), .busy(busy2)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // ---------------- reference model ----------------
    bit m_busy;
    bit m_alarm;
    int m_total;
    int m_win;
    bit win_q[$];   // hits of the window in progress
    int exp_q[$];   // expected win_count of each window report

    function automatic void model_edge(input bit r, input bit e, input bit c, input bit h);
        bit counted;
        bit set_alarm;
        int s;
        if (r) begin
            m_busy = 0; m_alarm = 0; m_total = 0; m_win = 0;
            win_q.delete();
            return;
        end
        counted   = m_busy && e;
        set_alarm = 0;
        if (m_busy) begin
            if (e) begin
                win_q.push_back(h);
                if (win_q.size() == WIN_LEN) begin
                    s = 0;
                    foreach (win_q[i]) s += int'(win_q[i]);
                    m_win = sat(s, MAX);
                    if (m_win >= THRESH) set_alarm = 1;
                    win_q.delete();
                    exp_q.push_back(m_win);
                end
            end else begin
                m_busy = 0;
                win_q.delete();
            end
        end else if (e) begin
            m_busy = 1;
            win_q.delete();
        end
        if (c) begin
            m_total = 0;
            m_alarm = 0;
        end
        if (counted && h) m_total = sat(m_total + 1, MAX);
        if (set_alarm) m_alarm = 1;
    endfunction

    // Drive one cycle of inputs, update the model at the edge, settle.
    task automatic step(input bit r, input bit e, input bit c, input bit h);
        rst = r; en = e; clr = c; hit_in = h;
        @(posedge clk);
        model_edge(r, e, c, h);
        #1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    bit mon_on = 0;
    int cyc_n = 0;
    int last_done_cyc = -1;
    int prev_done_cyc = -1;
    int exp_w;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    always @(negedge clk) begin
        if (mon_on) begin
            check("busy", busy, m_busy);
            check("alarm", alarm, m_alarm);
            check("total_count", total_count, m_total);
            check("win_count", win_count, m_win);
            check("win_done", win_done, exp_q.size() != 0);
            if (win_done) begin
                prev_done_cyc = last_done_cyc;
                last_done_cyc = cyc_n;
            end
            if (exp_q.size() != 0) begin
                exp_w = exp_q.pop_front();
                if (win_done) check("win_report", win_count, exp_w);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    int  n_hits;
    bit  seen;
    int  rv;

    initial begin
        rst = 1; en = 1; clr = 0; hit_in = 1; en2 = 0; hit2 = 0;

        // Reset held two cycles with en and hit_in high.
        step(1, 1, 0, 1);
        mon_on = 1;
        step(1, 1, 0, 1);
        check("rst_busy", busy, 0);
        check("rst_total", total_count, 0);
        step(0, 1, 0, 0);
        check("busy_after_rst", busy, 1);

        // Basic window: hits on cycles 3, 5, 10.
        for (int i = 0; i < WIN_LEN; i++) step(0, 1, 0, (i == 3 || i == 5 || i == 10));
        check("basic_done", win_done, 1);
        check("basic_count", win_count, 3);
        check("basic_alarm", alarm, 1);
        check("basic_total", total_count, 3);

        // Back-to-back: window A hits 0,2,15; window B one hit.
        for (int i = 0; i < WIN_LEN; i++) step(0, 1, 0, (i == 0 || i == 2 || i == 15));
        check("b2b_a_count", win_count, 3);
        for (int i = 0; i < WIN_LEN; i++) step(0, 1, 0, (i == 4));
        check("b2b_b_count", win_count, 1);
        check("b2b_spacing", last_done_cyc - prev_done_cyc, WIN_LEN);
        check("b2b_alarm", alarm, 1);
        check("b2b_total", total_count, 7);

        // Abort at cycle 8 with hit_in high on the abort edge.
        for (int i = 0; i < 8; i++) step(0, 1, 0, (i == 1 || i == 4));
        step(0, 0, 0, 1);
        check("abort_busy", busy, 0);
        check("abort_win", win_count, 1);
        check("abort_total", total_count, 9);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
        check("idle_total", total_count, 9);

        // clr alone while idle, then window of 4 completing on a clr edge.
        step(0, 0, 1, 0);
        check("clr_alarm", alarm, 0);
        check("clr_total", total_count, 0);
        step(0, 1, 0, 0);
        for (int i = 0; i < WIN_LEN; i++) step(0, 1, (i == WIN_LEN - 1), (i < 4));
        check("collide_alarm", alarm, 1);
        check("collide_win", win_count, 4);
        check("collide_total", total_count, 0);
        step(0, 1, 1, 0);
        check("clr2_alarm", alarm, 0);
        check("clr2_total", total_count, 0);
        check("clr2_win", win_count, 4);
        step(0, 1, 1, 1);
        check("clr_hit_total", total_count, 1);

        // Random phase.
        for (int i = 0; i < 3000; i++) begin
            rv = int'($urandom_range(0, 999));
            step(rv < 3, $urandom_range(0, 99) >= 3, $urandom_range(0, 99) < 3,
                 $urandom_range(0, 99) < 45);
        end

        // Saturation on the narrow instance, main instance idle.
        step(0, 0, 0, 0);
        en2 = 1; hit2 = 1;
        step(0, 0, 0, 0);   // enter COUNT
        n_hits = 0;
        seen   = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            step(0, 0, 0, 0);
            n_hits++;
            if (n_hits == 20) check("sat_total_mid", total_count2, sat(20, MAX2));
            if (win_done2) begin
                seen = 1;
                check("sat_win", win_count2, sat(WIN_LEN2, MAX2));
                check("sat_total", total_count2, sat(n_hits, MAX2));
                check("sat_busy", busy2, 1);
            end
        end
        check("sat_done_seen", seen, 1);
        en2 = 0; hit2 = 0;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_hit_monitor.md
Name: seq_hit_monitor

Overview:
- Downstream consumer of the overlapping "1010" Moore detector.
- Takes the detector's one-bit detect output, counts detections over fixed-length cycle windows, and reports each window's count.
- Raises a sticky alarm when any window reaches a threshold, and keeps a saturating lifetime hit total.
- Feeds status/interrupt logic; all outputs are registered.

Parameters:
- CNT_W, 8, width of the window count and total count; both saturate at 2^CNT_W-1.
- WIN_LEN, 16, window length in clock cycles; legal range 2..2^16.
- THRESH, 3, window count at or above which the alarm is set; legal range 1..2^CNT_W-1.

Ports:
- clk, input, 1, system clock; all logic on rising edge.
- rst, input, 1, synchronous active-high reset.
- en, input, 1, monitor enable (level).
- clr, input, 1, one-cycle pulse; clears alarm and total_count.
- hit_in, input, 1, detector output; each cycle it is high counts as one hit.
- win_count, output, CNT_W, count of the last completed window (saturated).
- win_done, output, 1, one-cycle pulse; win_count was just updated.
- alarm, output, 1, sticky; set when a completed window count >= THRESH.
- total_count, output, CNT_W, saturating count of all hits seen in state COUNT.
- busy, output, 1, high while state is COUNT.

Behaviour:
- Reset is synchronous and active-high, sampled on the rising edge of clk. It overrides all other inputs.
- On reset: state=IDLE, cycle counter=0, window accumulator=0, win_count=0, win_done=0, alarm=0, total_count=0, busy=0.
- FSM has two states, IDLE and COUNT.
  - IDLE: counters held. If en=1 at an edge, go to COUNT with cycle counter=0 and accumulator=0. hit_in is ignored in IDLE.
  - COUNT: window cycle index = cycle counter (0..WIN_LEN-1). Each edge adds hit_in to the accumulator (saturating) and increments the cycle counter.
- Window end, at the edge where cycle counter==WIN_LEN-1 and en=1:
  - win_count <= sat(acc + hit_in).
  - win_done <= 1 for exactly one cycle.
  - If sat(acc + hit_in) >= THRESH, alarm <= 1.
  - Accumulator and cycle counter return to 0; state stays COUNT, giving back-to-back windows with no gap cycle.
- en=0 at any edge in COUNT, including the final window cycle:
  - Go to IDLE; the partial window is discarded.
  - win_count, win_done and alarm are not updated; win_done=0.
  - The hit_in of that cycle is not counted in total_count either.
- total_count: increments by 1 at every edge where state=COUNT, en=1 and hit_in=1. It saturates and holds at 2^CNT_W-1.
- clr: at the edge, alarm <= 0 and total_count <= 0.
  - If a window end sets alarm in the same edge, alarm=1 (set wins).
  - If a counted hit coincides with clr, total_count <= 1.
  - clr has no effect on state, win_count or the accumulator.
- Saturation: the accumulator never wraps; win_count reports 2^CNT_W-1 if exceeded.
- busy = (state==COUNT), registered with the state.
- Latency:
  - en sampled high at edge k: first counted window cycle is the cycle following edge k.
  - win_done is high in the cycle after the last window cycle's edge.
- Reset mid-window: everything returns to reset values at that edge; no win_done is produced.

Test Plan:
- Reset (WIN_LEN=16, THRESH=3): hold rst 2 cycles with en=1, hit_in=1 -> all outputs 0 and busy=0 through the reset cycles; busy=1 one edge after rst drops.
- Basic window: en=1; hit_in pulses on window cycles 3, 5 and 10 -> win_done one cycle after cycle 15; win_count=3, alarm=1, total_count=3.
- Back-to-back windows: hits on window cycles 0, 2 and 15 of window A, then 1 hit in window B -> win_count=3 then 1, win_done pulses exactly 16 cycles apart, alarm stays 1, total_count=4.
- Abort: en=1, 2 hits, drop en at cycle 8 -> busy=0, no win_done, win_count unchanged (0), total_count=2. Re-enable -> the new window starts from 0.
- clr/set collision: assert clr on the same edge a window completes with count 4 -> alarm=1. clr alone one cycle later -> alarm=0 and total_count=0; win_count=4 unchanged.
- Saturation (CNT_W=4, WIN_LEN=32): hit_in=1 constant -> win_count=15, total_count holds at 15, no wrap to 0.
